reg_list_sequencer: RTL and testbench
=====================================

Name: reg_list_sequencer

Overview:
- Multi-cycle controller that sequences the register file for PUSH/POP (block transfer) instructions.
- Walks a register list lowest-first and drives the read select for stores, or the write destination and enable for loads.
- Issues one memory beat per register, then writes back the updated SP.
- Sits between the decoder and register_file. Holds pc_en low while busy so the PC does not advance mid-sequence.

Parameters:
- DATA_WIDTH, 32, width of address offsets.
- ADDR_STEP, 4, byte stride per transferred register.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request. Sampled only in IDLE.
- is_pop  input  1  1 = POP (load), 0 = PUSH (store). Latched at start.
- reg_list  input  8  R0..R7 mask, bit i = Ri. Latched at start.
- extra_bit  input  1  PUSH: include LR; POP: include PC. Latched at start.
- mem_ready  input  1  memory beat complete in this cycle.
- mem_req  output  1  memory beat request.
- mem_we  output  1  1 = store beat.
- addr_offset  output  DATA_WIDTH  signed byte offset relative to current SP for this beat.
- regA_select  output  4  register file read port A select (store data).
- regB_select  output  4  register file read port B select. Fixed to SP (4'b1000) while busy.
- write_dest  output  4  register file write destination.
- write_en  output  1  register file write enable.
- wb_sel_sp  output  1  0 = write data from memory, 1 = SP + sp_offset.
- sp_offset  output  DATA_WIDTH  signed SP adjustment: -ADDR_STEP*count for PUSH, +ADDR_STEP*count for POP.
- pc_en  output  1  PC advance enable. 0 while busy.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse.
- branch_flush  output  1  see Optional Feature.

Behaviour:
- Register encodings: R0..R7 = 4'b0000..4'b0111, SP = 4'b1000, PC = 4'b1001, LR = 4'b1010.
- Internal 9-bit mask = {extra_bit, reg_list}. Bit 8 maps to LR for PUSH and PC for POP.
- count = popcount(mask), 0..9. index = beats completed, 0..8.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, mask=0, index=0.
  - Outputs: mem_req=0, mem_we=0, write_en=0, wb_sel_sp=0, done=0, busy=0, pc_en=1, branch_flush=0.
  - All selects and offsets = 0.
  - Reset mid-sequence aborts immediately; no SP writeback occurs.
- States:
  - IDLE: busy=0, pc_en=1. On start, latch inputs. If mask==0 go to DONE, else go to XFER.
  - XFER:
    - busy=1, pc_en=0, mem_req=1, mem_we=~is_pop.
    - cur = lowest set bit of mask.
    - PUSH: regA_select = encoding(cur), addr_offset = -ADDR_STEP*count + ADDR_STEP*index.
    - POP: write_dest = encoding(cur), addr_offset = ADDR_STEP*index, write_en = mem_ready (Mealy), wb_sel_sp=0.
    - On mem_ready: clear bit cur, index++. If the mask is now empty, go to SP_WB.
    - Without mem_ready, hold all outputs stable.
  - SP_WB: exactly one cycle. write_dest=SP, write_en=1, wb_sel_sp=1, mem_req=0, sp_offset valid. Go to DONE.
  - DONE: done=1, busy=1, pc_en=0 for exactly one cycle. Go to IDLE.
- Latency:
  - start sampled at edge k → first beat presented from cycle k+1.
  - With mem_ready always 1, total = count + 2 cycles to the done pulse (XFER beats + SP_WB + DONE).
  - Empty list: done in cycle k+1. No mem_req, no write_en, no SP change.
- start asserted while not in IDLE is ignored; it is not queued.
- sp_offset and addr_offset are computed in DATA_WIDTH two's complement. They wrap modulo 2^DATA_WIDTH.
- All state and output registers change only on the rising edge of clk. Only write_en in POP XFER is combinational on mem_ready.

Optional Feature:
- Macro: POP_PC_FLUSH_EN.
- Defined: branch_flush=1 during the DONE cycle when is_pop=1 and extra_bit=1 (PC was loaded); 0 otherwise.
- Undefined: branch_flush tied to 0 and no extra logic is generated.

Decomposition:
- Shared package/header:
  - register encodings (R0..R7, SP, PC, LR, IMM = 4'b1111);
  - state encodings (IDLE, XFER, SP_WB, DONE);
  - ADDR_STEP default.
- One sub-module: reg_list_priority_enc. Input is the 9-bit mask plus is_pop; outputs are the lowest-set index, its 4-bit register encoding, and an empty flag.
- popcount stays inline.

Test Plan:
1. Reset and idle:
   - Stimulus: rst_n=0 for 2 cycles, then 1, no start.
   - Required: busy=0, mem_req=0, write_en=0, done=0, pc_en=1.
2. PUSH {R0,R2,LR}, mem_ready=1 throughout:
   - Stimulus: reg_list=8'b00000101, extra_bit=1, is_pop=0.
   - Beats in order: regA_select=0000 with offset 0xFFFFFFF4; 0010 with 0xFFFFFFF8; 1010 with 0xFFFFFFFC.
   - SP_WB: write_dest=1000, sp_offset=0xFFFFFFF4.
   - done pulses 5 cycles after start.
3. POP {R1,PC} with mem_ready low for 2 cycles per beat:
   - Outputs hold during stalls.
   - write_en only on ready cycles: write_dest=0001 at offset 0, then 1001 at offset 4.
   - SP_WB sp_offset=0x8.
   - With POP_PC_FLUSH_EN: branch_flush=1 in the DONE cycle.
4. Empty list:
   - Stimulus: reg_list=0, extra_bit=0, start.
   - Required: done next cycle, mem_req never asserted, write_en never asserted.
5. Reset mid-sequence:
   - Stimulus: rst_n=0 during the second beat of an 8-register PUSH.
   - Required: IDLE at the next edge, no SP_WB cycle, pc_en=1.
6. Start while busy:
   - Stimulus: assert start during XFER with a different reg_list.
   - Required: ignored; the original sequence completes unchanged and exactly one done pulse occurs.

Source files
------------

// File: rtl/reg_list_sequencer_pkg.sv
// Shared encodings for the PUSH/POP register list sequencer.
// Register file selects, FSM states and default stride.
package reg_list_sequencer_pkg;

  localparam logic [3:0] REG_R0  = 4'b0000;
  localparam logic [3:0] REG_R7  = 4'b0111;
  localparam logic [3:0] REG_SP  = 4'b1000;
  localparam logic [3:0] REG_PC  = 4'b1001;
  localparam logic [3:0] REG_LR  = 4'b1010;
  localparam logic [3:0] REG_IMM = 4'b1111;

  localparam int ADDR_STEP_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_SP_WB,
    S_DONE
  } state_t;

endpackage

// File: rtl/reg_list_sequencer_if.sv
// Memory beat bus between the sequencer and the load/store unit.
// master = sequencer, slave = memory side.
interface reg_list_sequencer_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] addr_offset;
  logic                  mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_offset,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_offset,
    output mem_ready
  );

endinterface

// File: rtl/reg_list_priority_enc.sv
// Lowest-set-bit finder over the 9-bit transfer mask.
// Bit 8 maps to PC for POP and LR for PUSH.
module reg_list_priority_enc
  import reg_list_sequencer_pkg::*;
(
  input  logic [8:0] mask,
  input  logic       is_pop,
  output logic [3:0] idx,
  output logic [3:0] enc,
  output logic       empty
);

  always_comb begin
    idx   = '0;
    empty = (mask == '0);
    for (int i = 8; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
  end

  always_comb begin
    enc = REG_R0;
    unique case (1'b1)
      empty:   enc = REG_R0;
      idx[3]:  enc = is_pop ? REG_PC : REG_LR;
      default: enc = idx;
    endcase
  end

endmodule

// File: rtl/reg_list_sequencer.sv
// PUSH/POP block transfer sequencer: one memory beat per listed register, then SP writeback.
// Optional: define POP_PC_FLUSH_EN to flag a branch flush when POP loads PC.
module reg_list_sequencer
  import reg_list_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_STEP  = ADDR_STEP_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_pop,
  input  logic [7:0]            reg_list,
  input  logic                  extra_bit,
  reg_list_sequencer_if.master  mem,
  output logic [3:0]            regA_select,
  output logic [3:0]            regB_select,
  output logic [3:0]            write_dest,
  output logic                  write_en,
  output logic                  wb_sel_sp,
  output logic [DATA_WIDTH-1:0] sp_offset,
  output logic                  pc_en,
  output logic                  busy,
  output logic                  done,
  output logic                  branch_flush
);

  state_t     state, state_nx;
  logic [8:0] mask, mask_nx;
  logic [3:0] index, index_nx;
  logic [3:0] count, count_nx;
  logic       pop_q, pop_nx;

  logic [8:0] start_mask;
  logic [3:0] start_cnt;
  logic [3:0] cur_idx;
  logic [3:0] cur_enc;
  logic       cur_empty;
  logic [8:0] cleared;

  logic [DATA_WIDTH-1:0] step_w;
  logic [DATA_WIDTH-1:0] span;
  logic [DATA_WIDTH-1:0] idx_off;

  assign start_mask = {extra_bit, reg_list};

  always_comb begin
    start_cnt = '0;
    for (int i = 0; i < 9; i++) begin
      start_cnt = start_cnt + {3'b000, start_mask[i]};
    end
  end

  reg_list_priority_enc u_penc (
    .mask   (mask),
    .is_pop (pop_q),
    .idx    (cur_idx),
    .enc    (cur_enc),
    .empty  (cur_empty)
  );

  assign cleared = mask & ~(9'b1 << cur_idx);
  assign step_w  = DATA_WIDTH'(ADDR_STEP);
  assign span    = DATA_WIDTH'(count) * step_w;
  assign idx_off = DATA_WIDTH'(index) * step_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mask  <= '0;
      index <= '0;
      count <= '0;
      pop_q <= 1'b0;
    end else begin
      state <= state_nx;
      mask  <= mask_nx;
      index <= index_nx;
      count <= count_nx;
      pop_q <= pop_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    mask_nx         = mask;
    index_nx        = index;
    count_nx        = count;
    pop_nx          = pop_q;
    mem.mem_req     = 1'b0;
    mem.mem_we      = 1'b0;
    mem.addr_offset = '0;
    regA_select     = REG_R0;
    regB_select     = REG_R0;
    write_dest      = REG_R0;
    write_en        = 1'b0;
    wb_sel_sp       = 1'b0;
    sp_offset       = '0;
    pc_en           = 1'b1;
    busy            = 1'b0;
    done            = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          mask_nx  = start_mask;
          count_nx = start_cnt;
          pop_nx   = is_pop;
          index_nx = '0;
          state_nx = (start_mask == '0) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        busy        = 1'b1;
        pc_en       = 1'b0;
        regB_select = REG_SP;
        mem.mem_req = 1'b1;
        mem.mem_we  = ~pop_q;
        if (pop_q) begin
          write_dest      = cur_enc;
          write_en        = mem.mem_ready;
          mem.addr_offset = idx_off;
        end else begin
          regA_select     = cur_enc;
          mem.addr_offset = idx_off - span;
        end
        // Beat retires only on ready; otherwise everything above holds.
        if (mem.mem_ready && !cur_empty) begin
          mask_nx  = cleared;
          index_nx = index + 4'd1;
          if (cleared == '0) state_nx = S_SP_WB;
        end
      end
      S_SP_WB: begin
        busy        = 1'b1;
        pc_en       = 1'b0;
        regB_select = REG_SP;
        write_dest  = REG_SP;
        write_en    = 1'b1;
        wb_sel_sp   = 1'b1;
        sp_offset   = pop_q ? span : ('0 - span);
        state_nx    = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        pc_en       = 1'b0;
        regB_select = REG_SP;
        done        = 1'b1;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef POP_PC_FLUSH_EN
  logic flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      flush_q <= is_pop & extra_bit;
    end
  end

  assign branch_flush = (state == S_DONE) & flush_q;
`else
  assign branch_flush = 1'b0;
`endif

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Directed self-checking bench for reg_list_sequencer.
// Each scenario task drives stimulus and checks inline.
module tb_reg_list_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_pop;
  logic [7:0]  reg_list;
  logic        extra_bit;
  logic [3:0]  regA_select;
  logic [3:0]  regB_select;
  logic [3:0]  write_dest;
  logic        write_en;
  logic        wb_sel_sp;
  logic [31:0] sp_offset;
  logic        pc_en;
  logic        busy;
  logic        done;
  logic        branch_flush;

  int checks = 0;
  int errors = 0;

`ifdef POP_PC_FLUSH_EN
  logic exp_flush = 1'b1;
`else
  logic exp_flush = 1'b0;
`endif

  reg_list_sequencer_if #(.DATA_WIDTH(32)) mem ();

  reg_list_sequencer #(.DATA_WIDTH(32), .ADDR_STEP(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_pop       (is_pop),
    .reg_list     (reg_list),
    .extra_bit    (extra_bit),
    .mem          (mem.master),
    .regA_select  (regA_select),
    .regB_select  (regB_select),
    .write_dest   (write_dest),
    .write_en     (write_en),
    .wb_sel_sp    (wb_sel_sp),
    .sp_offset    (sp_offset),
    .pc_en        (pc_en),
    .busy         (busy),
    .done         (done),
    .branch_flush (branch_flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    is_pop = 1'b0;
    reg_list = 8'h00;
    extra_bit = 1'b0;
    mem.mem_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, mem.mem_req, write_en, done, pc_en, branch_flush}
        !== 6'b000010) begin
      errors++;
      $display("FAIL reset_idle: busy/req/we/done/pc_en/flush got %b want 000010",
               {busy, mem.mem_req, write_en, done, pc_en, branch_flush});
    end
    checks++;
    if ({regA_select, regB_select, write_dest, mem.addr_offset, sp_offset}
        !== 76'h0) begin
      errors++;
      $display("FAIL reset_sel: selects/offsets got %h want 0",
               {regA_select, regB_select, write_dest, mem.addr_offset, sp_offset});
    end
  endtask

  task automatic test_push();
    logic [3:0]  exp_sel [3] = '{4'b0000, 4'b0010, 4'b1010};
    logic [31:0] exp_off [3] = '{32'hFFFFFFF4, 32'hFFFFFFF8, 32'hFFFFFFFC};
    is_pop = 1'b0;
    reg_list = 8'b00000101;
    extra_bit = 1'b1;
    mem.mem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      checks++;
      if ({mem.mem_req, mem.mem_we, write_en, busy, pc_en, done} !== 6'b110100) begin
        errors++;
        $display("FAIL push_ctl%0d: req/we/wen/busy/pc_en/done got %b want 110100",
                 b, {mem.mem_req, mem.mem_we, write_en, busy, pc_en, done});
      end
      checks++;
      if (regA_select !== exp_sel[b] || mem.addr_offset !== exp_off[b]
          || regB_select !== 4'b1000) begin
        errors++;
        $display("FAIL push_beat%0d: sel %b off %h regB %b want %b %h 1000",
                 b, regA_select, mem.addr_offset, regB_select, exp_sel[b], exp_off[b]);
      end
      tick();
    end
    checks++;
    if ({mem.mem_req, write_en, wb_sel_sp} !== 3'b011 || write_dest !== 4'b1000
        || sp_offset !== 32'hFFFFFFF4) begin
      errors++;
      $display("FAIL push_spwb: req/we/sel %b dest %b sp_off %h want 011 1000 fffffff4",
               {mem.mem_req, write_en, wb_sel_sp}, write_dest, sp_offset);
    end
    tick();
    checks++;
    if ({done, busy, pc_en, branch_flush} !== 4'b1100) begin
      errors++;
      $display("FAIL push_done: done/busy/pc_en/flush got %b want 1100",
               {done, busy, pc_en, branch_flush});
    end
    tick();
    checks++;
    if ({done, busy, pc_en} !== 3'b001) begin
      errors++;
      $display("FAIL push_idle: done/busy/pc_en got %b want 001", {done, busy, pc_en});
    end
  endtask

  task automatic test_pop_stall();
    logic [3:0]  exp_dst [2] = '{4'b0001, 4'b1001};
    logic [31:0] exp_off [2] = '{32'h0, 32'h4};
    is_pop = 1'b1;
    reg_list = 8'b00000010;
    extra_bit = 1'b1;
    mem.mem_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 2; s++) begin
        mem.mem_ready = 1'b0;
        #1;
        checks++;
        if ({mem.mem_req, mem.mem_we, write_en} !== 3'b100
            || write_dest !== exp_dst[b] || mem.addr_offset !== exp_off[b]) begin
          errors++;
          $display("FAIL pop_stall%0d_%0d: req/we/wen %b dest %b off %h want 100 %b %h",
                   b, s, {mem.mem_req, mem.mem_we, write_en}, write_dest,
                   mem.addr_offset, exp_dst[b], exp_off[b]);
        end
        tick();
      end
      mem.mem_ready = 1'b1;
      #1;
      checks++;
      if ({mem.mem_req, mem.mem_we, write_en, wb_sel_sp} !== 4'b1010
          || write_dest !== exp_dst[b] || mem.addr_offset !== exp_off[b]) begin
        errors++;
        $display("FAIL pop_ready%0d: req/we/wen/wbsel %b dest %b off %h want 1010 %b %h",
                 b, {mem.mem_req, mem.mem_we, write_en, wb_sel_sp}, write_dest,
                 mem.addr_offset, exp_dst[b], exp_off[b]);
      end
      tick();
    end
    mem.mem_ready = 1'b0;
    #1;
    checks++;
    if ({mem.mem_req, write_en, wb_sel_sp} !== 3'b011 || write_dest !== 4'b1000
        || sp_offset !== 32'h8) begin
      errors++;
      $display("FAIL pop_spwb: req/we/sel %b dest %b sp_off %h want 011 1000 00000008",
               {mem.mem_req, write_en, wb_sel_sp}, write_dest, sp_offset);
    end
    tick();
    checks++;
    if (done !== 1'b1 || branch_flush !== exp_flush) begin
      errors++;
      $display("FAIL pop_done: done %b flush %b want 1 %b", done, branch_flush, exp_flush);
    end
    tick();
    checks++;
    if ({done, busy, branch_flush} !== 3'b000) begin
      errors++;
      $display("FAIL pop_idle: done/busy/flush got %b want 000",
               {done, busy, branch_flush});
    end
  endtask

  task automatic test_empty();
    is_pop = 1'b0;
    reg_list = 8'h00;
    extra_bit = 1'b0;
    mem.mem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({done, busy, pc_en, mem.mem_req, write_en} !== 5'b11000) begin
      errors++;
      $display("FAIL empty_done: done/busy/pc_en/req/we got %b want 11000",
               {done, busy, pc_en, mem.mem_req, write_en});
    end
    tick();
    checks++;
    if ({done, busy, pc_en, mem.mem_req, write_en} !== 5'b00100) begin
      errors++;
      $display("FAIL empty_idle: done/busy/pc_en/req/we got %b want 00100",
               {done, busy, pc_en, mem.mem_req, write_en});
    end
  endtask

  task automatic test_reset_mid();
    is_pop = 1'b0;
    reg_list = 8'hFF;
    extra_bit = 1'b0;
    mem.mem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (regA_select !== 4'd0 || mem.addr_offset !== 32'hFFFFFFE0) begin
      errors++;
      $display("FAIL rstmid_beat0: sel %b off %h want 0000 ffffffe0",
               regA_select, mem.addr_offset);
    end
    tick();
    checks++;
    if (regA_select !== 4'd1 || mem.addr_offset !== 32'hFFFFFFE4) begin
      errors++;
      $display("FAIL rstmid_beat1: sel %b off %h want 0001 ffffffe4",
               regA_select, mem.addr_offset);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, pc_en, mem.mem_req, write_en, wb_sel_sp} !== 5'b01000) begin
      errors++;
      $display("FAIL rstmid_abort: busy/pc_en/req/we/wbsel got %b want 01000",
               {busy, pc_en, mem.mem_req, write_en, wb_sel_sp});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, pc_en, write_en, wb_sel_sp, done} !== 5'b01000) begin
      errors++;
      $display("FAIL rstmid_nowb: busy/pc_en/we/wbsel/done got %b want 01000",
               {busy, pc_en, write_en, wb_sel_sp, done});
    end
  endtask

  task automatic test_start_busy();
    int dones = 0;
    is_pop = 1'b0;
    reg_list = 8'b00011000;
    extra_bit = 1'b0;
    mem.mem_ready = 1'b1;
    start = 1'b1;
    tick();
    checks++;
    if (regA_select !== 4'd3 || mem.addr_offset !== 32'hFFFFFFF8) begin
      errors++;
      $display("FAIL busy_beat0: sel %b off %h want 0011 fffffff8",
               regA_select, mem.addr_offset);
    end
    is_pop = 1'b1;
    reg_list = 8'hFF;
    extra_bit = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (regA_select !== 4'd4 || mem.addr_offset !== 32'hFFFFFFFC
        || mem.mem_we !== 1'b1 || write_en !== 1'b0) begin
      errors++;
      $display("FAIL busy_beat1: sel %b off %h we %b wen %b want 0100 fffffffc 1 0",
               regA_select, mem.addr_offset, mem.mem_we, write_en);
    end
    tick();
    checks++;
    if (wb_sel_sp !== 1'b1 || sp_offset !== 32'hFFFFFFF8) begin
      errors++;
      $display("FAIL busy_spwb: wbsel %b sp_off %h want 1 fffffff8", wb_sel_sp, sp_offset);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_onedone: done pulses %0d busy %b want 1 0", dones, busy);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop_stall();
    test_empty();
    test_reset_mid();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
